// File: rtl/ar_rxd.sv
// ARINC-429-style receiver: recovers a 32-bit bipolar RZ word from RXD1/RXD0,
// checks odd parity and presents the label/data with one-cycle result strobes.
module ar_rxd #(
  parameter int TB_HS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Nvel,
  input  logic        RXD1,
  input  logic        RXD0,
  output logic [7:0]  ADR,
  output logic [22:0] DAT,
  output logic        ok_rx,
  output logic        err_par,
  output logic        err_frm,
  output logic        busy,
  output logic [5:0]  cb_bit
);

  // Wide enough for the 2*Tb idle count at the slowest rate.
  localparam int CW = $clog2(16 * TB_HS + 1);
  localparam logic [CW-1:0] TB_N0 = CW'(8 * TB_HS);
  localparam logic [CW-1:0] TB_N1 = CW'(2 * TB_HS);
  localparam logic [CW-1:0] TB_N2 = CW'(TB_HS);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          r1_m_q, r1_q, r0_m_q, r0_q;
  logic          a_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tb_q, tb_d;
  logic          bval_q, bval_d;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    cb_q, cb_d;
  logic [7:0]    adr_q, adr_d;
  logic [22:0]   dat_q, dat_d;
  logic          ok_q, ok_d;
  logic          par_q, par_d;
  logic          frm_q, frm_d;

  logic          a_now, rise, line_hi;
  logic          err, go_sync;
  logic [CW-1:0] nvel_tb, q1, q3, q5, two_tb, cnt_inc;
  logic [7:0]    adr_rx;
  logic [22:0]   dat_rx;

  assign a_now   = r1_q | r0_q;
  assign rise    = a_now & ~a_prev_q;
  assign line_hi = bval_q ? r1_q : r0_q;
  assign q1      = tb_q >> 2;
  assign q3      = tb_q - q1;
  assign q5      = tb_q + q1;
  assign two_tb  = tb_q << 1;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    case (Nvel)
      2'd0:    nvel_tb = TB_N0;
      2'd1:    nvel_tb = TB_N1;
      default: nvel_tb = TB_N2;
    endcase
  end

  // First bit received lands in sr_q[31]; data goes out LSB first on the line.
  always_comb begin
    adr_rx = sr_q[31:24];
    dat_rx = '0;
    for (int i = 0; i < 23; i++) dat_rx[i] = sr_q[23-i];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    tb_d    = tb_q;
    bval_d  = bval_q;
    sr_d    = sr_q;
    cb_d    = cb_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    ok_d    = 1'b0;
    par_d   = 1'b0;
    frm_d   = 1'b0;
    err     = 1'b0;
    go_sync = 1'b0;
    case (state_q)
      S_SYNC: begin
        cb_d = '0;
        if (a_now) begin
          cnt_d = '0;
        end else if (cnt_q >= two_tb) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = S_HIGH;
          bval_d  = r1_q;
        end
      end
      S_HIGH: begin
        if (r1_q & r0_q) begin
          err = 1'b1;
        end else if (cnt_q == q1) begin
          if (line_hi) begin
            sr_d = {sr_q[30:0], bval_q};
            cb_d = cb_q + 6'd1;
          end else begin
            err = 1'b1;
          end
        end else if (a_now && cnt_q >= q3) begin
          err = 1'b1;
        end else if (!a_now && cnt_q > q1) begin
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cb_q == 6'd32) begin
          state_d = S_DONE;
          if (^sr_q) begin
            ok_d  = 1'b1;
            adr_d = adr_rx;
            dat_d = dat_rx;
          end else begin
            par_d = 1'b1;
          end
        end else if (rise) begin
          if (cnt_q >= q3) begin
            state_d = S_HIGH;
            cnt_d   = '0;
            bval_d  = r1_q;
          end else begin
            err = 1'b1;
          end
        end else if (cnt_q >= q5) begin
          err = 1'b1;
        end
      end
      S_DONE:  go_sync = 1'b1;
      default: go_sync = 1'b1;
    endcase
    if (err) begin
      frm_d   = 1'b1;
      go_sync = 1'b1;
    end
    // Rate is captured only here so a mid-word Nvel change cannot disturb timing.
    if (go_sync) begin
      state_d = S_SYNC;
      cnt_d   = '0;
      cb_d    = '0;
      tb_d    = nvel_tb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_m_q   <= 1'b0;
      r1_q     <= 1'b0;
      r0_m_q   <= 1'b0;
      r0_q     <= 1'b0;
      a_prev_q <= 1'b0;
      state_q  <= S_SYNC;
      cnt_q    <= '0;
      tb_q     <= nvel_tb;
      bval_q   <= 1'b0;
      sr_q     <= '0;
      cb_q     <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      ok_q     <= 1'b0;
      par_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      r1_m_q   <= RXD1;
      r1_q     <= r1_m_q;
      r0_m_q   <= RXD0;
      r0_q     <= r0_m_q;
      a_prev_q <= a_now;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tb_q     <= tb_d;
      bval_q   <= bval_d;
      sr_q     <= sr_d;
      cb_q     <= cb_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      ok_q     <= ok_d;
      par_q    <= par_d;
      frm_q    <= frm_d;
    end
  end

  assign ADR     = adr_q;
  assign DAT     = dat_q;
  assign ok_rx   = ok_q;
  assign err_par = par_q;
  assign err_frm = frm_q;
  assign busy    = (state_q == S_HIGH) || (state_q == S_LOW);
  assign cb_bit  = cb_q;

endmodule

// File: tb/tb_ar_rxd.sv
// Directed bench for ar_rxd: a line driver emits RZ bit pulses and each result
// is checked against hand-computed labels, data and strobe timing.
module tb_ar_rxd;

  localparam int TB_HS = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Nvel;
  logic        RXD1, RXD0;
  logic [7:0]  ADR;
  logic [22:0] DAT;
  logic        ok_rx, err_par, err_frm, busy;
  logic [5:0]  cb_bit;

  int n_checks = 0;
  int n_errors = 0;
  int ok_n = 0, par_n = 0, frm_n = 0, multi_n = 0;
  int ok0, par0, frm0, n;
  logic [31:0] w;

  ar_rxd #(.TB_HS(TB_HS)) dut (
    .clk(clk), .rst(rst), .Nvel(Nvel), .RXD1(RXD1), .RXD0(RXD0),
    .ADR(ADR), .DAT(DAT), .ok_rx(ok_rx), .err_par(err_par),
    .err_frm(err_frm), .busy(busy), .cb_bit(cb_bit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ok_rx) ok_n++;
    if (err_par) par_n++;
    if (err_frm) frm_n++;
    if ((ok_rx + err_par + err_frm) > 1) multi_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmit order: w[31] first (ADR[7]), data LSB first, parity last.
  function automatic logic [31:0] mk_word(input logic [7:0] adr, input logic [22:0] dat,
                                          input logic bad);
    logic [22:0] rev;
    for (int i = 0; i < 23; i++) rev[i] = dat[22-i];
    mk_word = {adr, rev, (~(^{adr, dat})) ^ bad};
  endfunction

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int hi, input int lo);
    if (b) RXD1 = 1'b1;
    else   RXD0 = 1'b1;
    idle(hi);
    RXD1 = 1'b0;
    RXD0 = 1'b0;
    if (lo > 0) idle(lo);
  endtask

  task automatic send_bits(input logic [31:0] wd, input int first, input int last,
                           input int tbp, input int last_lo);
    for (int i = first; i <= last; i++)
      drive_bit(wd[31-i], tbp / 2, (i == last) ? last_lo : tbp / 2);
  endtask

  // Returns the number of clocks until the selected strobe is seen, or -1.
  task automatic wait_strobe(input int sel, input int maxc, output int cnt);
    logic found;
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < maxc) begin
      @(posedge clk);
      #1;
      cnt++;
      if ((sel == 0 && ok_rx) || (sel == 1 && err_par) || (sel == 2 && err_frm)) found = 1'b1;
    end
    if (!found) cnt = -1;
  endtask

  initial begin
    rst = 1'b1; Nvel = 2'd1; RXD1 = 1'b0; RXD0 = 1'b0;
    idle(5);
    check("rst_adr", ADR, 0);
    check("rst_dat", DAT, 0);
    check("rst_busy", busy, 0);
    check("rst_cb", cb_bit, 0);
    check("rst_strobes", {ok_rx, err_par, err_frm}, 0);
    rst = 1'b0;
    idle(240);

    // Good word at Nvel=1 (Tb=80).
    ok0 = ok_n; par0 = par_n; frm0 = frm_n;
    w = mk_word(8'hFF, 23'h111111, 1'b0);
    send_bits(w, 0, 31, 80, 0);
    wait_strobe(0, 400, n);
    check("t1_ok_latency", n, 4);
    check("t1_adr", ADR, 8'hFF);
    check("t1_dat", DAT, 23'h111111);
    check("t1_cb_done", cb_bit, 32);
    idle(240);
    check("t1_no_err", (par_n - par0) + (frm_n - frm0), 0);
    check("t1_ok_once", ok_n - ok0, 1);

    // Second word; Nvel moves to 2 mid-word and must not disturb it.
    w = mk_word(8'h82, 23'h567800, 1'b0);
    send_bits(w, 0, 15, 80, 40);
    Nvel = 2'd2;
    send_bits(w, 16, 31, 80, 0);
    wait_strobe(0, 400, n);
    check("t2_ok_latency", n, 4);
    check("t2_adr", ADR, 8'h82);
    check("t2_dat", DAT, 23'h567800);
    idle(120);
    check("t2_cb_zero", cb_bit, 0);

    // Bad parity at Nvel=2 (Tb=40).
    ok0 = ok_n;
    w = mk_word(8'hFF, 23'h111111, 1'b1);
    send_bits(w, 0, 31, 40, 0);
    wait_strobe(1, 200, n);
    check("t3_par_latency", n, 4);
    check("t3_adr_hold", ADR, 8'h82);
    check("t3_dat_hold", DAT, 23'h567800);
    idle(120);
    check("t3_no_ok", ok_n - ok0, 0);

    // Timing violations at Nvel=2: glitch, both lines, truncated word.
    ok0 = ok_n;
    w = mk_word(8'hFF, 23'h111111, 1'b0);
    send_bits(w, 0, 4, 40, 20);
    drive_bit(1'b1, 4, 0);
    wait_strobe(2, 200, n);
    check("t4_glitch_frm", n, 10);
    idle(120);
    RXD1 = 1'b1; RXD0 = 1'b1;
    wait_strobe(2, 50, n);
    check("t4_both_frm", n, 4);
    idle(16);
    RXD1 = 1'b0; RXD0 = 1'b0;
    idle(120);
    send_bits(w, 0, 9, 40, 20);
    Nvel = 2'd0;
    wait_strobe(2, 200, n);
    check("t4_stop_frm", n, 14);
    check("t4_no_ok", ok_n - ok0, 0);
    idle(960);

    // Reset during bit 20 at Nvel=0 (Tb=320).
    w = mk_word(8'h3C, 23'h2AAAAA, 1'b0);
    send_bits(w, 0, 18, 320, 160);
    RXD1 = w[31-19];
    RXD0 = ~w[31-19];
    idle(40);
    check("t5_cb_pre", cb_bit, 19);
    check("t5_busy_pre", busy, 1);
    ok0 = ok_n; par0 = par_n; frm0 = frm_n;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t5_rst_adr", ADR, 0);
    check("t5_rst_dat", DAT, 0);
    check("t5_rst_flags", {busy, cb_bit, ok_rx, err_par, err_frm}, 0);
    idle(119);
    RXD1 = 1'b0; RXD0 = 1'b0;
    idle(160);
    send_bits(w, 20, 31, 320, 160);
    check("t5_no_strobe", (ok_n - ok0) + (par_n - par0) + (frm_n - frm0), 0);
    idle(960);
    send_bits(w, 0, 31, 320, 0);
    wait_strobe(0, 1000, n);
    check("t5_ok_latency", n, 4);
    check("t5_adr", ADR, 8'h3C);
    check("t5_dat", DAT, 23'h2AAAAA);
    idle(960);

    // Reset released while a word is already on the line, Nvel=2.
    Nvel = 2'd2;
    ok0 = ok_n; par0 = par_n; frm0 = frm_n;
    rst = 1'b1;
    w = mk_word(8'h55, 23'h0F0F0F, 1'b0);
    send_bits(w, 0, 9, 40, 20);
    rst = 1'b0;
    send_bits(w, 10, 31, 40, 20);
    idle(120);
    check("t6_no_strobe", (ok_n - ok0) + (par_n - par0) + (frm_n - frm0), 0);
    w = mk_word(8'hA1, 23'h000003, 1'b0);
    send_bits(w, 0, 31, 40, 0);
    wait_strobe(0, 200, n);
    check("t6_ok_latency", n, 4);
    check("t6_adr", ADR, 8'hA1);
    check("t6_dat", DAT, 23'h000003);
    idle(20);
    check("strobe_exclusive", multi_n, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
